// File: rtl/wddl_ctrl_pkg.sv
// Shared definitions for the WDDL precharge/evaluate phase controller.
// Holds the state encodings, the rail-check mode select and the bundle of
// registered control outputs with its per-state decode.
package wddl_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE_ENC    = 3'd0;
    localparam logic [STATE_W-1:0] PRECH_ENC   = 3'd1;
    localparam logic [STATE_W-1:0] EVAL_ENC    = 3'd2;
    localparam logic [STATE_W-1:0] CAPTURE_ENC = 3'd3;
    localparam logic [STATE_W-1:0] DONE_ENC    = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = IDLE_ENC,
        PRECH   = PRECH_ENC,
        EVAL    = EVAL_ENC,
        CAPTURE = CAPTURE_ENC,
        DONE    = DONE_ENC
    } state_e;

    localparam int unsigned CHK_MODE_W = 2;

    typedef enum logic [CHK_MODE_W-1:0] {
        CHK_OFF   = 2'd0,
        CHK_PRECH = 2'd1,
        CHK_EVAL  = 2'd2
    } chk_mode_e;

    typedef struct packed {
        logic prech;
        logic eval;
        logic load;
        logic done;
        logic busy;
    } ctrl_out_t;

    // Control outputs as a pure function of the state they will reflect.
    function automatic ctrl_out_t decode_outputs(input state_e s);
        ctrl_out_t o;
        o.prech = 1'b1;
        o.eval  = 1'b0;
        o.load  = 1'b0;
        o.done  = 1'b0;
        o.busy  = 1'b1;
        case (s)
            IDLE:    o.busy = 1'b0;
            PRECH:   ;
            EVAL: begin
                o.prech = 1'b0;
                o.eval  = 1'b1;
            end
            CAPTURE: begin
                o.prech = 1'b0;
                o.eval  = 1'b1;
                o.load  = 1'b1;
            end
            DONE:    o.done = 1'b1;
            default: o.busy = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/wddl_rail_chk.sv
// Dual-rail sanity check on the monitored datapath result.
//   mode_i    : CHK_OFF / CHK_PRECH / CHK_EVAL
//   mon_p_i   : true rail, WIDTH bits
//   mon_n_i   : false rail, WIDTH bits
//   viol_c_o  : combinational violation for the current mode
// In precharge every rail must be 0; at capture every bit pair must be
// complementary.
module wddl_rail_chk
    import wddl_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [CHK_MODE_W-1:0] mode_i,
    input  logic [WIDTH-1:0]      mon_p_i,
    input  logic [WIDTH-1:0]      mon_n_i,
    output logic                  viol_c_o
);

    always_comb begin
        viol_c_o = 1'b0;
        case (mode_i)
            CHK_PRECH: viol_c_o = |(mon_p_i | mon_n_i);
            CHK_EVAL:  viol_c_o = |(~(mon_p_i ^ mon_n_i));
            default:   viol_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/wddl_phase_ctrl.sv
// WDDL precharge/evaluate phase sequencer.
// Runs ROUNDS rounds of PRECH (1 cycle) -> EVAL (EVAL_CYCLES) -> CAPTURE (1),
// then a one-cycle DONE pulse. All control outputs are registered.
// Build option: define WDDL_RAIL_CHECK_EN to compile in the sticky dual-rail
// checker; otherwise rail_err_out is tied 0 and mon_* are ignored.
//   clk_in, rst_in          : clock, synchronous active-high reset
//   start_in                : operation request, accepted only in IDLE
//   mon_p_in / mon_n_in     : dual-rail datapath result
//   prech_out / eval_out    : datapath phase controls
//   load_out                : round result capture enable
//   round_out               : current round index
//   busy_out / done_out     : activity / completion pulse
//   rail_err_out            : sticky rail violation
module wddl_phase_ctrl
    import wddl_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ROUNDS      = 10,
    parameter int unsigned EVAL_CYCLES = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] mon_p_in,
    input  logic [WIDTH-1:0] mon_n_in,
    output logic             prech_out,
    output logic             eval_out,
    output logic             load_out,
    output logic [CNT_W-1:0] round_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             rail_err_out
);

    localparam int unsigned EVAL_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   round_q, round_d;
    logic [EVAL_W-1:0]  ecnt_q, ecnt_d;
    ctrl_out_t          out_q, out_d;

    // Next-state and next-output logic; outputs are decoded from the next
    // state so that the registered copy tracks state_q exactly.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        ecnt_d  = ecnt_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = PRECH;
                    round_d = '0;
                end
            end
            PRECH: begin
                state_d = EVAL;
                ecnt_d  = '0;
            end
            EVAL: begin
                if (ecnt_q == EVAL_W'(EVAL_CYCLES - 1)) begin
                    state_d = CAPTURE;
                end else begin
                    ecnt_d = ecnt_q + EVAL_W'(1);
                end
            end
            CAPTURE: begin
                if (round_q == CNT_W'(ROUNDS - 1)) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + CNT_W'(1);
                    state_d = PRECH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        out_d = decode_outputs(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            round_q <= '0;
            ecnt_q  <= '0;
            out_q   <= decode_outputs(IDLE);
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            ecnt_q  <= ecnt_d;
            out_q   <= out_d;
        end
    end

    assign prech_out = out_q.prech;
    assign eval_out  = out_q.eval;
    assign load_out  = out_q.load;
    assign done_out  = out_q.done;
    assign busy_out  = out_q.busy;
    assign round_out = round_q;

`ifdef WDDL_RAIL_CHECK_EN
    chk_mode_e mode_c;
    logic      viol_c;
    logic      rail_err_q, rail_err_d;

    // Precharge phase checks for all-zero rails, capture for complementarity.
    always_comb begin
        mode_c = CHK_OFF;
        case (state_q)
            PRECH:   mode_c = CHK_PRECH;
            CAPTURE: mode_c = CHK_EVAL;
            default: mode_c = CHK_OFF;
        endcase
    end

    wddl_rail_chk #(
        .WIDTH (WIDTH)
    ) u_rail_chk (
        .mode_i   (mode_c),
        .mon_p_i  (mon_p_in),
        .mon_n_i  (mon_n_in),
        .viol_c_o (viol_c)
    );

    // Sticky flag; an accepted start clears it for the new operation.
    always_comb begin
        rail_err_d = rail_err_q | viol_c;
        if (state_q == IDLE && start_in) begin
            rail_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rail_err_q <= 1'b0;
        end else begin
            rail_err_q <= rail_err_d;
        end
    end

    assign rail_err_out = rail_err_q;
`else
    logic unused_mon;
    assign unused_mon   = ^{mon_p_in, mon_n_in};
    assign rail_err_out = 1'b0;
`endif

endmodule

// File: doc/wddl_phase_ctrl.md
WDDL_PHASE_CTRL -- requirements
Module: wddl_phase_ctrl

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 8: bit width of the monitored dual-rail bus.
- REQ-002 The block SHALL have parameter ROUNDS, default 10: number of precharge/evaluate rounds per operation (1..2**CNT_W).
- REQ-003 The block SHALL have parameter EVAL_CYCLES, default 1: cycles the datapath holds evaluate before capture (>=1).
- REQ-004 The block SHALL have parameter CNT_W, default 4: width of the round counter.
- REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
- REQ-006 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is rising-edge.
- REQ-007 The block SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
- REQ-008 The block SHALL have port start_in, input, 1 bit: operation request.
- REQ-009 The block SHALL have port mon_p_in, input, WIDTH bits: true rail of the datapath result.
- REQ-010 The block SHALL have port mon_n_in, input, WIDTH bits: false rail of the datapath result.
- REQ-011 The block SHALL have port prech_out, output, 1 bit: 1 forces all datapath dual-rail inputs to 0/0.
- REQ-012 The block SHALL have port eval_out, output, 1 bit: 1 releases datapath inputs to complementary values.
- REQ-013 The block SHALL have port load_out, output, 1 bit: capture enable for the round result register.
- REQ-014 The block SHALL have port round_out, output, CNT_W bits: current round index.
- REQ-015 The block SHALL have port busy_out, output, 1 bit: high in every state except IDLE.
- REQ-016 The block SHALL have port done_out, output, 1 bit: one-cycle completion pulse.
- REQ-017 The block SHALL have port rail_err_out, output, 1 bit: sticky dual-rail violation flag.

Function
- REQ-018 The FSM SHALL have states IDLE, PRECH, EVAL, CAPTURE and DONE, all outputs driven from registered state.
- REQ-019 In IDLE the block SHALL drive prech_out=1 and eval_out=0; start_in=1 moves it to PRECH with round_out=0.
- REQ-020 start_in SHALL be ignored in every state other than IDLE, including the DONE cycle.
- REQ-021 PRECH SHALL last exactly 1 cycle (prech_out=1, eval_out=0), then go to EVAL.
- REQ-022 EVAL SHALL last exactly EVAL_CYCLES cycles (prech_out=0, eval_out=1), then go to CAPTURE.
- REQ-023 CAPTURE SHALL last 1 cycle with eval_out=1 and load_out=1; load_out SHALL be 0 in all other states.
- REQ-024 From CAPTURE, the block SHALL go to DONE if round_out==ROUNDS-1, else increment round_out and go to PRECH.
- REQ-025 DONE SHALL last 1 cycle with done_out=1 and prech_out=1, then go to IDLE; round_out SHALL hold its last value until the next start.
- REQ-026 For start sampled at edge k, done_out SHALL be high in cycle k+1+(EVAL_CYCLES+2)*ROUNDS (31 for the defaults).
- REQ-027 prech_out and eval_out SHALL never both be 1, and SHALL never both be 0 except in EVAL/CAPTURE handover, where eval_out stays 1.
- REQ-028 Rail check SHALL flag an error when, in PRECH, any bit has mon_p_in|mon_n_in = 1.
- REQ-029 Rail check SHALL flag an error when, in CAPTURE, any bit has mon_p_in==mon_n_in.
- REQ-030 rail_err_out SHALL be sticky and SHALL be cleared only by reset or by an accepted start.

Reset
- REQ-031 While rst_in=1 at a clock edge, the block SHALL enter IDLE with round_out=0, done_out=0, load_out=0, busy_out=0, rail_err_out=0, prech_out=1 and eval_out=0.
- REQ-032 Reset asserted mid-operation SHALL abort that operation with no done_out pulse, and reset SHALL take priority over start_in.

Configuration
- REQ-033 With macro WDDL_RAIL_CHECK_EN defined, rail checking SHALL be compiled in as specified in REQ-028 to REQ-030.
- REQ-034 Without WDDL_RAIL_CHECK_EN, rail_err_out SHALL be tied 0, the mon_* ports SHALL remain present but unused, and sequencing SHALL be unchanged.

Structure
- REQ-035 The state encoding constants and the IDLE/PRECH/EVAL/CAPTURE/DONE localparams SHALL live in the shared package wddl_ctrl_pkg.
- REQ-036 The rail check SHALL be a sub-module wddl_rail_chk (WIDTH parameter, mode select, violation output), instantiated only under WDDL_RAIL_CHECK_EN.

Verification
- REQ-037 Nominal operation, defaults: pulse start -> 10 load_out pulses 3 cycles apart, round_out 0..9, done_out at cycle k+31, busy_out low the next cycle.
- REQ-038 Busy start: hold start_in=1 for the whole operation -> exactly one operation, then a new one starting from IDLE right after DONE.
- REQ-039 Mid-operation reset: rst_in=1 during round 4 EVAL -> next cycle IDLE, round_out=0, prech_out=1, no done_out pulse.
- REQ-040 Precharge violation (macro on): mon_p_in=8'h01, mon_n_in=0 during PRECH -> rail_err_out=1 next cycle, held through done, cleared on next start.
- REQ-041 Evaluate violation (macro on): mon_p_in=mon_n_in=8'hFF at CAPTURE -> rail_err_out=1; same stimulus with macro off -> rail_err_out stays 0.
- REQ-042 Parameter sweep: ROUNDS=1, EVAL_CYCLES=3 -> done_out at cycle k+6, exactly one load_out pulse, and prech_out/eval_out never both 1.
